master_port: RTL and testbench

MASTER_PORT -- requirements
Module: master_port

---
 rtl/master_port.sv | 129 ++++++++++++
 tb/tb_master_port.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/master_port.sv
// Bit-serial master: accepts a local read/write request and shifts address/data to a serial slave.
// Optional read timeout is compiled in with `define MASTER_PORT_TIMEOUT_EN.
module master_port #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dvalid,
  input  logic                  dmode,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dready,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  drvalid,
  output logic                  ddone,
  output logic                  derr,
  output logic                  mwdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  srdata,
  input  logic                  svalid,
  input  logic                  sready
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW) + 1;

  typedef enum logic [2:0] {
    IDLE, WAIT_READY, ADDR, WDATA, RWAIT, RDATA, DONE
  } state_t;

  state_t                state, nstate;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] addr_sh;
  logic [DATA_WIDTH-1:0] data_sh;
  logic [DATA_WIDTH-1:0] rsh;
  logic                  mode_q;
  logic                  tmo;
  logic                  last_rbit;

  // The read bit that completes a word: RWAIT holds bit 0, RDATA gathers the rest.
  assign last_rbit = (state == RDATA) && svalid && (cnt == CW'(DATA_WIDTH-2));

`ifdef MASTER_PORT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic          err_q;

  assign tmo = (tcnt == TW'(TIMEOUT_CYCLES-1)) && !svalid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt  <= (state == RWAIT) ? tcnt + 1'b1 : '0;
      err_q <= (state == RWAIT) && tmo;
    end
  end

  assign derr    = (state == DONE) && err_q;
  assign drvalid = (state == DONE) && !mode_q && !err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign tmo     = 1'b0;
  assign derr    = 1'b0;
  assign drvalid = (state == DONE) && !mode_q;
`endif

  always_comb begin
    nstate = state;
    case (state)
      IDLE:       if (dvalid) nstate = WAIT_READY;
      WAIT_READY: if (sready) nstate = ADDR;
      ADDR:       if (cnt == CW'(ADDR_WIDTH-1)) nstate = mode_q ? WDATA : RWAIT;
      WDATA:      if (cnt == CW'(DATA_WIDTH-1)) nstate = DONE;
      RWAIT: begin
        if (svalid)   nstate = RDATA;
        else if (tmo) nstate = DONE;
      end
      RDATA:      if (last_rbit) nstate = DONE;
      DONE:       nstate = IDLE;
      default:    nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_sh <= '0;
      data_sh <= '0;
      rsh     <= '0;
      mode_q  <= 1'b0;
      drdata  <= '0;
    end else begin
      state <= nstate;
      if (nstate != state)
        cnt <= '0;
      else if (state == ADDR || state == WDATA || (state == RDATA && svalid))
        cnt <= cnt + 1'b1;

      if (state == IDLE && dvalid) begin
        addr_sh <= daddr;
        data_sh <= dwdata;
        mode_q  <= dmode;
      end
      if (state == ADDR)  addr_sh <= addr_sh >> 1;
      if (state == WDATA) data_sh <= data_sh >> 1;

      // Shift in from the top so the first bit received lands in bit 0.
      if ((state == RWAIT || state == RDATA) && svalid)
        rsh <= {srdata, rsh[DATA_WIDTH-1:1]};
      if (last_rbit)
        drdata <= {srdata, rsh[DATA_WIDTH-1:1]};
    end
  end

  assign dready = (state == IDLE);
  assign ddone  = (state == DONE);
  assign mvalid = (state == ADDR) || (state == WDATA);
  assign mmode  = (state != IDLE) && mode_q;
  assign mwdata = (state == ADDR)  ? addr_sh[0] :
                  (state == WDATA) ? data_sh[0] : 1'b0;

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: write, read, ready stall, read gap, reset abort, optional timeout.
module tb_master_port;
  localparam int AW = 12;
  localparam int DW = 8;
`ifdef MASTER_PORT_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          dvalid = 1'b0;
  logic          dmode = 1'b0;
  logic [AW-1:0] daddr = '0;
  logic [DW-1:0] dwdata = '0;
  logic          srdata = 1'b0;
  logic          svalid = 1'b0;
  logic          sready = 1'b0;
  logic          dready, drvalid, ddone, derr, mwdata, mmode, mvalid;
  logic [DW-1:0] drdata;

  int checks = 0;
  int failures = 0;

  master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .dvalid(dvalid), .dmode(dmode), .daddr(daddr),
    .dwdata(dwdata), .dready(dready), .drdata(drdata), .drvalid(drvalid),
    .ddone(ddone), .derr(derr), .mwdata(mwdata), .mmode(mmode), .mvalid(mvalid),
    .srdata(srdata), .svalid(svalid), .sready(sready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #2;
    checks++;
    if ({dready, drvalid, ddone, derr, mwdata, mmode, mvalid} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=1000000",
               {dready, drvalid, ddone, derr, mwdata, mmode, mvalid});
    end
    checks++;
    if (drdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_drdata got=%h exp=00", drdata);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_write();
    bit exp[20] = '{1,0,1,0,0,1,0,1,0,0,0,0, 0,0,1,1,1,1,0,0};
    dvalid = 1'b1; dmode = 1'b1; daddr = 12'h0A5; dwdata = 8'h3C; sready = 1'b1;
    step();
    dvalid = 1'b0; daddr = 12'hFFF; dwdata = 8'h00;
    checks++;
    if ({dready, mvalid, mmode} !== 3'b001) begin
      failures++;
      $display("FAIL write_wait got=%b exp=001", {dready, mvalid, mmode});
    end
    step();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({mvalid, mmode, mwdata, ddone} !== {2'b11, exp[i], 1'b0}) begin
        failures++;
        $display("FAIL write_bit%0d got=%b exp=%b", i, {mvalid, mmode, mwdata, ddone},
                 {2'b11, exp[i], 1'b0});
      end
      step();
    end
    checks++;
    if ({ddone, drvalid, mvalid, mwdata, derr} !== 5'b10000) begin
      failures++;
      $display("FAIL write_done got=%b exp=10000", {ddone, drvalid, mvalid, mwdata, derr});
    end
    step();
    checks++;
    if ({ddone, dready, mmode} !== 3'b010) begin
      failures++;
      $display("FAIL write_idle got=%b exp=010", {ddone, dready, mmode});
    end
  endtask

  task automatic test_read();
    bit rb[8] = '{0,1,1,0,1,0,0,1};
    dvalid = 1'b1; dmode = 1'b0; daddr = 12'hFFF; sready = 1'b1;
    step();
    dvalid = 1'b0;
    step();
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({mvalid, mmode, mwdata} !== 3'b101) begin
        failures++;
        $display("FAIL read_addr%0d got=%b exp=101", i, {mvalid, mmode, mwdata});
      end
      step();
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({mvalid, mwdata, mmode, ddone} !== 4'b0000) begin
        failures++;
        $display("FAIL read_rwait%0d got=%b exp=0000", i, {mvalid, mwdata, mmode, ddone});
      end
      step();
    end
    for (int k = 0; k < 8; k++) begin
      srdata = rb[k]; svalid = 1'b1;
      checks++;
      if (ddone !== 1'b0) begin
        failures++;
        $display("FAIL read_early_done bit=%0d got=%b exp=0", k, ddone);
      end
      step();
    end
    svalid = 1'b0; srdata = 1'b0;
    checks++;
    if ({drdata, drvalid, ddone, derr} !== {8'h96, 3'b110}) begin
      failures++;
      $display("FAIL read_done got=%h/%b exp=96/110", drdata, {drvalid, ddone, derr});
    end
    step();
    checks++;
    if ({drdata, drvalid, ddone, dready} !== {8'h96, 3'b001}) begin
      failures++;
      $display("FAIL read_hold got=%h/%b exp=96/001", drdata, {drvalid, ddone, dready});
    end
  endtask

  task automatic test_ready();
    dvalid = 1'b1; dmode = 1'b1; daddr = 12'h001; dwdata = 8'h81; sready = 1'b0;
    step();
    dvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({mvalid, dready} !== 2'b00) begin
        failures++;
        $display("FAIL ready_stall%0d got=%b exp=00", i, {mvalid, dready});
      end
      step();
    end
    sready = 1'b1;
    step();
    sready = 1'b0;
    checks++;
    if ({mvalid, mwdata} !== 2'b11) begin
      failures++;
      $display("FAIL ready_addr_start got=%b exp=11", {mvalid, mwdata});
    end
    for (int i = 1; i < 20; i++) begin
      step();
      checks++;
      if (mvalid !== 1'b1) begin
        failures++;
        $display("FAIL ready_mvalid%0d got=%b exp=1", i, mvalid);
      end
    end
    step();
    checks++;
    if ({ddone, mvalid} !== 2'b10) begin
      failures++;
      $display("FAIL ready_done got=%b exp=10", {ddone, mvalid});
    end
    step();
  endtask

  task automatic test_gap();
    bit rb[8] = '{0,1,0,1,1,0,1,0};
    dvalid = 1'b1; dmode = 1'b0; daddr = 12'h123; sready = 1'b1;
    step();
    dvalid = 1'b0;
    step();
    for (int i = 0; i < 12; i++) step();
    for (int k = 0; k < 4; k++) begin
      srdata = rb[k]; svalid = 1'b1;
      step();
    end
    svalid = 1'b0; srdata = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({drdata, ddone, drvalid} !== {8'h96, 2'b00}) begin
        failures++;
        $display("FAIL gap_hold%0d got=%h/%b exp=96/00", i, drdata, {ddone, drvalid});
      end
      step();
    end
    for (int k = 4; k < 8; k++) begin
      srdata = rb[k]; svalid = 1'b1;
      step();
    end
    svalid = 1'b0; srdata = 1'b0;
    checks++;
    if ({drdata, drvalid, ddone} !== {8'h5A, 2'b11}) begin
      failures++;
      $display("FAIL gap_result got=%h/%b exp=5a/11", drdata, {drvalid, ddone});
    end
    step();
  endtask

  task automatic test_reset_abort();
    dvalid = 1'b1; dmode = 1'b1; daddr = 12'h0A5; dwdata = 8'h3C; sready = 1'b1;
    step();
    dvalid = 1'b0;
    step();
    for (int i = 0; i < 6; i++) step();
    checks++;
    if ({mvalid, mwdata} !== 2'b10) begin
      failures++;
      $display("FAIL abort_bit6 got=%b exp=10", {mvalid, mwdata});
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({mvalid, dready, mmode, mwdata, drdata} !== {4'b0100, 8'h00}) begin
      failures++;
      $display("FAIL abort_reset got=%b/%h exp=0100/00", {mvalid, dready, mmode, mwdata}, drdata);
    end
    @(negedge clk);
    rstn = 1'b1;
    dvalid = 1'b1; dmode = 1'b1; daddr = 12'h001; dwdata = 8'hFF;
    step();
    dvalid = 1'b0;
    checks++;
    if ({dready, mmode} !== 2'b01) begin
      failures++;
      $display("FAIL abort_accept got=%b exp=01", {dready, mmode});
    end
    step();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({mvalid, mwdata} !== {1'b1, (i == 0) || (i >= 12)}) begin
        failures++;
        $display("FAIL abort_bit%0d got=%b exp=%b", i, {mvalid, mwdata},
                 {1'b1, (i == 0) || (i >= 12)});
      end
      step();
    end
    checks++;
    if (ddone !== 1'b1) begin
      failures++;
      $display("FAIL abort_done got=%b exp=1", ddone);
    end
    step();
  endtask

`ifdef MASTER_PORT_TIMEOUT_EN
  task automatic test_timeout();
    dvalid = 1'b1; dmode = 1'b0; daddr = 12'h000; sready = 1'b1; svalid = 1'b0;
    step();
    dvalid = 1'b0;
    step();
    for (int i = 0; i < 12; i++) step();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({ddone, derr} !== 2'b00) begin
        failures++;
        $display("FAIL timeout_early%0d got=%b exp=00", k, {ddone, derr});
      end
      step();
    end
    checks++;
    if ({ddone, derr, drvalid, drdata} !== {3'b110, 8'h00}) begin
      failures++;
      $display("FAIL timeout_done got=%b/%h exp=110/00", {ddone, derr, drvalid}, drdata);
    end
    step();
    checks++;
    if ({derr, dready} !== 2'b01) begin
      failures++;
      $display("FAIL timeout_idle got=%b exp=01", {derr, dready});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ready();
    test_gap();
    test_reset_abort();
`ifdef MASTER_PORT_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
